// File: rtl/weight_chk.sv
// weight_chk: computes the Hamming weight of a W-bit syndrome CHUNK bits per
// clock and flags whether the weight is at or below a selectable threshold.
// Optional feature: define WEIGHT_EARLY_EXIT_EN to end accumulation as soon as
// the running weight exceeds the threshold (result saturates to threshold+1).
module weight_chk #(
    parameter  int W       = 36,
    parameter  int CHUNK   = 6,
    parameter  int THR_DEF = 4,
    localparam int NCYC    = (W + CHUNK - 1) / CHUNK,
    localparam int WW      = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          si_valid,
    output logic          si_ready,
    input  logic [W-1:0]  si,
    input  logic          thr_sel,
    input  logic [WW-1:0] thr,
    output logic          done_valid,
    input  logic          done_ready,
    output logic [WW-1:0] weight,
    output logic          weight_flag
);

    // Chunk counter width; at least one bit even for a single-chunk syndrome.
    localparam int KW = (NCYC > 1) ? $clog2(NCYC) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [W-1:0]    si_reg, si_next;
    logic [WW-1:0]   thr_reg, thr_next;
    logic [WW-1:0]   acc_reg, acc_next;
    logic [KW-1:0]   k_reg, k_next;
    logic [WW-1:0]   weight_reg, weight_next;
    logic            flag_reg, flag_next;
    logic            ready_reg, ready_next;

    // Syndrome zero-extended to a whole number of chunks, so padding bits
    // in the last chunk contribute nothing to the count.
    logic [NCYC*CHUNK-1:0] padded;
    logic [CHUNK-1:0]      chunk_arr [NCYC];
    logic [CHUNK-1:0]      cur_chunk;
    logic [WW-1:0]         pop;
    logic [WW-1:0]         acc_sum;

    assign padded = (NCYC*CHUNK)'(si_reg);

    generate
        for (genvar gi = 0; gi < NCYC; gi++) begin : g_chunk
            assign chunk_arr[gi] = padded[gi*CHUNK +: CHUNK];
        end
    endgenerate

    assign cur_chunk = chunk_arr[k_reg];

    // Popcount of the chunk selected by the chunk counter.
    always_comb begin
        pop = '0;
        for (int i = 0; i < CHUNK; i++) begin
            pop = pop + WW'(cur_chunk[i]);
        end
    end

    // Running sum cannot exceed W, so WW bits never overflow.
    assign acc_sum = acc_reg + pop;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and datapath-next logic.
    always_comb begin
        state_next  = state_reg;
        si_next     = si_reg;
        thr_next    = thr_reg;
        acc_next    = acc_reg;
        k_next      = k_reg;
        weight_next = weight_reg;
        flag_next   = flag_reg;
        unique case (state_reg)
            IDLE: begin
                if (si_valid && ready_reg) begin
                    si_next    = si;
                    thr_next   = thr_sel ? thr : WW'(THR_DEF);
                    acc_next   = '0;
                    k_next     = '0;
                    state_next = ACC;
                end
            end
            ACC: begin
                acc_next = acc_sum;
                k_next   = k_reg + KW'(1);
`ifdef WEIGHT_EARLY_EXIT_EN
                if (acc_sum > thr_reg) begin
                    // Threshold already exceeded: thr_reg < W here, so +1 fits.
                    weight_next = thr_reg + WW'(1);
                    flag_next   = 1'b0;
                    state_next  = DONE;
                end else if (k_reg == KW'(NCYC - 1)) begin
                    weight_next = acc_sum;
                    flag_next   = (acc_sum <= thr_reg);
                    state_next  = DONE;
                end
`else
                if (k_reg == KW'(NCYC - 1)) begin
                    weight_next = acc_sum;
                    flag_next   = (acc_sum <= thr_reg);
                    state_next  = DONE;
                end
`endif
            end
            DONE: begin
                if (done_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Ready is registered so it reads 0 during reset and rises on the first
    // edge after release; it also blocks accept on the DONE->IDLE edge.
    assign ready_next = (state_next == IDLE);

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            si_reg     <= '0;
            thr_reg    <= '0;
            acc_reg    <= '0;
            k_reg      <= '0;
            weight_reg <= '0;
            flag_reg   <= 1'b0;
            ready_reg  <= 1'b0;
        end else begin
            si_reg     <= si_next;
            thr_reg    <= thr_next;
            acc_reg    <= acc_next;
            k_reg      <= k_next;
            weight_reg <= weight_next;
            flag_reg   <= flag_next;
            ready_reg  <= ready_next;
        end
    end

    assign si_ready    = ready_reg;
    assign done_valid  = (state_reg == DONE);
    assign weight      = weight_reg;
    assign weight_flag = flag_reg;

endmodule
